// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: one access at a time over a request/response bus, with byte-lane
// strobes for stores, sign/zero extension for loads, alignment checks and a response timeout.
module ysyx_25060170_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [1:0]  out_err
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       addr_lo;
    logic [2:0]       funct3;
    logic             is_load;

    logic       f3_legal, misalign, in_bus;
    logic [1:0] in_err;
    logic [3:0] st_strb;
    logic [31:0] st_data;

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b100:  extract = {24'h0, b};
            3'b101:  extract = {16'h0, h};
            default: extract = word;
        endcase
    endfunction

    // Classify the offered op: illegal size beats misalignment; non-memory ops skip the bus.
    always_comb begin
        f3_legal = 1'b0;
        if (in_is_load)
            f3_legal = in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (in_is_store)
            f3_legal = !in_funct3[2] && (in_funct3[1:0] != 2'b11);
        misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                   ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        in_bus = 1'b0;
        in_err = 2'b00;
        if (in_is_load || in_is_store) begin
            if (!f3_legal)     in_err = 2'b11;
            else if (misalign) in_err = 2'b01;
            else               in_bus = 1'b1;
        end
    end

    always_comb begin
        case (in_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << in_addr[1:0];
                st_data = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << in_addr[1:0];
                st_data = {2{in_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'hF;
                st_data = in_wdata;
            end
        endcase
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_lo       <= 2'b00;
            funct3        <= 3'b000;
            is_load       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= 32'h0;
            mem_req_wdata <= 32'h0;
            mem_req_wstrb <= 4'h0;
            out_valid     <= 1'b0;
            out_rdata     <= 32'h0;
            out_rd        <= 5'd0;
            out_we        <= 1'b0;
            out_err       <= 2'b00;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    addr_lo   <= in_addr[1:0];
                    funct3    <= in_funct3;
                    is_load   <= in_is_load;
                    out_rd    <= in_rd;
                    out_rdata <= 32'h0;
                    out_we    <= 1'b0;
                    out_err   <= in_err;
                    if (in_bus) begin
                        mem_req_addr  <= {in_addr[31:2], 2'b00};
                        mem_req_wen   <= !in_is_load;
                        mem_req_wstrb <= in_is_load ? 4'h0 : st_strb;
                        mem_req_wdata <= in_is_load ? 32'h0 : st_data;
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                // A response in the expiry cycle still counts as success.
                WAIT: if (mem_rsp_valid) begin
                    out_rdata <= is_load ? extract(funct3, addr_lo, mem_rsp_rdata) : 32'h0;
                    out_we    <= is_load && (out_rd != 5'd0);
                    out_err   <= 2'b00;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    out_err   <= 2'b10;
                    out_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_we    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Bench for ysyx_25060170_lsu: directed test-plan vectors plus randomized ops
// scored against a behavioural model of the access rules.
`timescale 1ns/1ps
module tb_ysyx_25060170_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_addr = '0, in_wdata = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_is_load = 1'b0, in_is_store = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        out_valid, out_ready = 1'b0, out_we;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;

    always #5 clk = ~clk;

    ysyx_25060170_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
        .out_we(out_we), .out_err(out_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by run_op
    logic        o_saw_req, o_req_stable, o_out_stable, o_ready_in_resp, o_hang;
    logic        o_ready_before, o_ready_after, o_valid_after, o_req_wen, o_we;
    logic [31:0] o_req_addr, o_req_wdata, o_rdata;
    logic [3:0]  o_req_wstrb;
    logic [1:0]  o_err;
    logic [4:0]  o_rd;
    int          o_lat;

    typedef struct {
        logic        bus;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wen;
        int          lat;
    } exp_t;

    function automatic exp_t model(input logic [31:0] a, wd, input logic [2:0] f3,
                                   input logic ld, st, input logic [4:0] rd,
                                   input int req_dly, rsp_dly, input logic [31:0] rdata);
        exp_t e;
        logic [31:0] b, h;
        int waits;
        e.bus = 0; e.err = 0; e.rdata = 0; e.we = 0; e.wdata = 0; e.wstrb = 0; e.wen = 0;
        e.addr = a & 32'hFFFF_FFFC;
        e.lat = 1;
        if (!ld && !st) return e;
        if (ld ? !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 > 2)) begin
            e.err = 2'b11; return e;
        end
        if ((f3[1:0] == 2'd1 && a % 2 != 0) || (f3[1:0] == 2'd2 && a % 4 != 0)) begin
            e.err = 2'b01; return e;
        end
        e.bus = 1;
        waits = (rsp_dly + 1 > TMO) ? TMO : rsp_dly + 1;
        e.lat = 2 + req_dly + waits;
        if (!ld) begin
            e.wen = 1;
            if (f3 == 0) begin
                e.wstrb = 4'(1 << (a % 4)); e.wdata = (wd & 32'hFF) * 32'h0101_0101;
            end else if (f3 == 1) begin
                e.wstrb = 4'(3 << (a % 4)); e.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            end else begin
                e.wstrb = 4'hF; e.wdata = wd;
            end
        end
        if (rsp_dly + 1 > TMO) begin e.err = 2'b10; return e; end
        if (ld) begin
            b = (rdata >> ((a % 4) * 8)) & 32'hFF;
            h = (rdata >> ((a % 4) / 2 * 16)) & 32'hFFFF;
            case (f3)
                3'd0: e.rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd1: e.rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                3'd4: e.rdata = b;
                3'd5: e.rdata = h;
                default: e.rdata = rdata;
            endcase
            e.we = (rd != 0);
        end
        return e;
    endfunction

    // Offers one op at a negedge in IDLE, plays the bus with the given delays
    // (rsp_dly extra WAIT cycles before the response pulse), holds out_ready low for 'hold' cycles.
    task automatic run_op(input logic [31:0] a, wd, input logic [2:0] f3, input logic ld, st,
                          input logic [4:0] rd, input int req_dly, rsp_dly,
                          input logic [31:0] rdata, input int hold);
        int cyc, req_cnt, wait_k, hold_cnt;
        logic in_wait, go_wait, done, seen_out;
        o_ready_before = in_ready;
        in_valid = 1; in_addr = a; in_wdata = wd; in_funct3 = f3;
        in_is_load = ld; in_is_store = st; in_rd = rd; mem_rsp_rdata = rdata;
        @(negedge clk);
        in_valid = 0;
        cyc = 1; req_cnt = 0; wait_k = 0; hold_cnt = 0;
        in_wait = 0; done = 0; seen_out = 0;
        o_saw_req = 0; o_req_stable = 1; o_out_stable = 1; o_ready_in_resp = 0; o_lat = -1;
        o_req_addr = 0; o_req_wdata = 0; o_req_wstrb = 0; o_req_wen = 0;
        o_rdata = 0; o_we = 0; o_err = 0; o_rd = 0;
        while (!done && cyc < 80) begin
            mem_rsp_valid = 0; mem_req_ready = 0; go_wait = 0;
            if (in_wait) begin
                wait_k++;
                mem_rsp_valid = (wait_k == rsp_dly + 1);
            end
            if (mem_req_valid) begin
                if (!o_saw_req) begin
                    o_saw_req = 1; o_req_addr = mem_req_addr; o_req_wdata = mem_req_wdata;
                    o_req_wstrb = mem_req_wstrb; o_req_wen = mem_req_wen;
                end else if ({mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen} !==
                             {o_req_addr, o_req_wdata, o_req_wstrb, o_req_wen}) begin
                    o_req_stable = 0;
                end
                if (req_cnt == req_dly) begin mem_req_ready = 1; go_wait = 1; end
                req_cnt++;
            end
            if (out_valid) begin
                in_wait = 0;
                if (!seen_out) begin
                    seen_out = 1; o_lat = cyc; o_rdata = out_rdata; o_we = out_we;
                    o_err = out_err; o_rd = out_rd;
                end else if ({out_rdata, out_we, out_err, out_rd} !== {o_rdata, o_we, o_err, o_rd}) begin
                    o_out_stable = 0;
                end
                if (in_ready) o_ready_in_resp = 1;
                if (hold_cnt == hold) begin out_ready = 1; done = 1; end
                hold_cnt++;
            end
            @(negedge clk);
            cyc++;
            out_ready = 0;
            if (go_wait) in_wait = 1;
        end
        mem_rsp_valid = 0; mem_req_ready = 0; out_ready = 0;
        o_hang = !done;
        o_ready_after = in_ready;
        o_valid_after = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mem_req_valid, out_valid, out_we} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl got=%b exp=000", {mem_req_valid, out_valid, out_we}); end
        n_cmp++; if ({out_rdata, out_rd, out_err} !== 39'h0) begin n_bad++; $display("FAIL reset_out got=%h exp=0", {out_rdata, out_rd, out_err}); end
        n_cmp++; if ({mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen} !== 69'h0) begin n_bad++; $display("FAIL reset_req got=%h exp=0", {mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_req_wen}); end
        rst_n = 1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_loads();
        run_op(32'h8000_0004, 0, 3'b010, 1, 0, 5'd5, 0, 0, 32'hDEAD_BEEF, 0);
        n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL lw_latency got=%0d exp=3", o_lat); end
        n_cmp++; if (o_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", o_rdata); end
        n_cmp++; if ({o_we, o_err, o_rd} !== {1'b1, 2'b00, 5'd5}) begin n_bad++; $display("FAIL lw_flags got=%b exp=%b", {o_we, o_err, o_rd}, {1'b1, 2'b00, 5'd5}); end
        n_cmp++; if (o_req_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL lw_addr got=%h exp=80000004", o_req_addr); end
        run_op(32'h8000_0003, 0, 3'b000, 1, 0, 5'd6, 0, 0, 32'h80FF_0011, 0);
        n_cmp++; if (o_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", o_rdata); end
        run_op(32'h8000_0003, 0, 3'b100, 1, 0, 5'd6, 0, 0, 32'h80FF_0011, 0);
        n_cmp++; if (o_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata got=%h exp=00000080", o_rdata); end
        run_op(32'h8000_0002, 0, 3'b101, 1, 0, 5'd0, 0, 1, 32'h80FF_0011, 0);
        n_cmp++; if (o_rdata !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu_rdata got=%h exp=000080ff", o_rdata); end
        n_cmp++; if (o_we !== 1'b0) begin n_bad++; $display("FAIL lhu_rd0_we got=%b exp=0", o_we); end
    endtask

    task automatic test_store();
        run_op(32'h8000_0006, 32'h1234_ABCD, 3'b001, 0, 1, 5'd9, 0, 0, 32'h5555_5555, 0);
        n_cmp++; if ({o_req_wen, o_req_wstrb} !== 5'b1_1100) begin n_bad++; $display("FAIL sh_wen_wstrb got=%b exp=11100", {o_req_wen, o_req_wstrb}); end
        n_cmp++; if (o_req_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", o_req_wdata); end
        n_cmp++; if (o_req_addr !== 32'h8000_0004) begin n_bad++; $display("FAIL sh_addr got=%h exp=80000004", o_req_addr); end
        n_cmp++; if ({o_we, o_err, o_rdata} !== 35'h0) begin n_bad++; $display("FAIL sh_result got=%h exp=0", {o_we, o_err, o_rdata}); end
    endtask

    task automatic test_errors();
        run_op(32'h8000_0002, 0, 3'b010, 1, 0, 5'd3, 0, 0, 32'h1111_1111, 0);
        n_cmp++; if ({o_saw_req, o_err} !== 3'b0_01) begin n_bad++; $display("FAIL misaligned got=%b exp=001", {o_saw_req, o_err}); end
        n_cmp++; if (o_lat !== 1) begin n_bad++; $display("FAIL misaligned_latency got=%0d exp=1", o_lat); end
        run_op(32'h8000_0000, 0, 3'b011, 1, 0, 5'd3, 0, 0, 32'h1111_1111, 0);
        n_cmp++; if ({o_saw_req, o_err, o_we} !== 4'b0_11_0) begin n_bad++; $display("FAIL illegal_f3 got=%b exp=0110", {o_saw_req, o_err, o_we}); end
    endtask

    task automatic test_timeout_and_stall();
        run_op(32'h8000_0008, 0, 3'b010, 1, 0, 5'd4, 0, 50, 32'h7777_7777, 0);
        n_cmp++; if ({o_err, o_rdata, o_we} !== {2'b10, 32'h0, 1'b0}) begin n_bad++; $display("FAIL timeout got=%h exp=%h", {o_err, o_rdata, o_we}, {2'b10, 32'h0, 1'b0}); end
        n_cmp++; if (o_lat !== 2 + TMO) begin n_bad++; $display("FAIL timeout_latency got=%0d exp=%0d", o_lat, 2 + TMO); end
        run_op(32'h8000_000C, 32'hCAFE_F00D, 3'b010, 0, 1, 5'd4, 5, 0, 32'h0, 3);
        n_cmp++; if ({o_saw_req, o_req_stable, o_out_stable} !== 3'b111) begin n_bad++; $display("FAIL stall_stable got=%b exp=111", {o_saw_req, o_req_stable, o_out_stable}); end
        n_cmp++; if (o_lat !== 8) begin n_bad++; $display("FAIL stall_latency got=%0d exp=8", o_lat); end
        n_cmp++; if (o_ready_in_resp !== 1'b0) begin n_bad++; $display("FAIL resp_in_ready got=%b exp=0", o_ready_in_resp); end
    endtask

    task automatic test_stray_rsp();
        mem_rsp_valid = 1;
        @(negedge clk);
        mem_rsp_valid = 0;
        @(negedge clk);
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL stray_rsp got=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_addr = 32'h8000_0010; in_funct3 = 3'b010;
        in_is_load = 1; in_is_store = 0; in_rd = 5'd7;
        @(negedge clk);
        in_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++; if ({mem_req_valid, out_valid, out_we, out_rd, out_err} !== 10'h0) begin n_bad++; $display("FAIL midreset_ctrl got=%b exp=0", {mem_req_valid, out_valid, out_we, out_rd, out_err}); end
        n_cmp++; if ({mem_req_addr, out_rdata} !== 64'h0) begin n_bad++; $display("FAIL midreset_data got=%h exp=0", {mem_req_addr, out_rdata}); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op(32'h8000_0020, 0, 3'b010, 1, 0, 5'd3, 0, 0, 32'h0BAD_F00D, 0);
        n_cmp++; if ({o_lat, o_rdata, o_err, o_we} !== {32'd3, 32'h0BAD_F00D, 2'b00, 1'b1}) begin n_bad++; $display("FAIL after_reset_lw got=%0d/%h/%b/%b exp=3/0badf00d/00/1", o_lat, o_rdata, o_err, o_we); end
    endtask

    // Consecutive random ops start on the cycle right after each out handshake.
    task automatic test_back_to_back();
        logic [31:0] a, wd, rdata;
        logic [2:0] f3;
        logic [4:0] rd;
        logic ld, st;
        int kind, rq, rs, hold;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            a = $urandom(); wd = $urandom(); rdata = $urandom();
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            f3 = 3'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 31));
            kind = $urandom_range(0, 9);
            ld = (kind >= 1 && kind <= 5); st = (kind >= 6);
            rq = $urandom_range(0, 3); rs = $urandom_range(0, 6); hold = $urandom_range(0, 2);
            e = model(a, wd, f3, ld, st, rd, rq, rs, rdata);
            run_op(a, wd, f3, ld, st, rd, rq, rs, rdata, hold);
            n_cmp++; if (o_hang !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_no_result got=%b exp=0", i, o_hang); end
            n_cmp++; if (o_ready_before !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready_before got=%b exp=1", i, o_ready_before); end
            n_cmp++; if (o_lat !== e.lat) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, o_lat, e.lat); end
            n_cmp++; if ({o_err, o_rdata, o_we, o_rd} !== {e.err, e.rdata, e.we, rd}) begin n_bad++; $display("FAIL rnd%0d_result got=%b/%h/%b/%0d exp=%b/%h/%b/%0d", i, o_err, o_rdata, o_we, o_rd, e.err, e.rdata, e.we, rd); end
            n_cmp++; if (o_saw_req !== e.bus) begin n_bad++; $display("FAIL rnd%0d_bus got=%b exp=%b", i, o_saw_req, e.bus); end
            if (e.bus) begin
                n_cmp++; if ({o_req_addr, o_req_wen, o_req_wstrb} !== {e.addr, e.wen, e.wstrb}) begin n_bad++; $display("FAIL rnd%0d_req got=%h/%b/%b exp=%h/%b/%b", i, o_req_addr, o_req_wen, o_req_wstrb, e.addr, e.wen, e.wstrb); end
                if (e.wen) begin
                    n_cmp++; if (o_req_wdata !== e.wdata) begin n_bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_req_wdata, e.wdata); end
                end
                n_cmp++; if (o_req_stable !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_req_stable got=%b exp=1", i, o_req_stable); end
            end
            n_cmp++; if ({o_out_stable, o_ready_in_resp} !== 2'b10) begin n_bad++; $display("FAIL rnd%0d_resp_hold got=%b exp=10", i, {o_out_stable, o_ready_in_resp}); end
            n_cmp++; if ({o_ready_after, o_valid_after} !== 2'b10) begin n_bad++; $display("FAIL rnd%0d_after_handshake got=%b exp=10", i, {o_ready_after, o_valid_after}); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_loads();
        test_store();
        test_errors();
        test_timeout_and_stall();
        test_stray_rsp();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
